bcd_stopwatch_core: RTL and testbench
=====================================

// Module: bcd_stopwatch_core
// PURPOSE
//  Parametrised multi-digit BCD stopwatch counter with run/stop/lap/clear control.
//  Each digit has its own modulus, so MM:SS and similar formats fall out of the parameters.
//  Counting is driven by a 1-cycle tick_en pulse from the upstream prescaler.
//  Feeds the 7-segment display mux through the frozen-capable disp bus.
// PARAMETERS
//  DIGITS     4        number of BCD digits (1..8)
//  DIGIT_MOD  16'h6A6A 4 bits per digit, digit0 = LSB nibble; modulus of each digit (2..10, A=10)
//  WRAP_MODE  1        1: wrap to all-zero on overflow; 0: saturate at max and stop
// PORTS
//  clk        in   1          system clock
//  reset      in   1          asynchronous, active-low reset
//  tick_en    in   1          count-enable pulse, one count per high cycle
//  start_stop in   1          1-cycle pulse, toggles run/stop
//  lap_reset  in   1          1-cycle pulse: lap when running, clear when stopped
//  count      out  4*DIGITS   live BCD count
//  disp       out  4*DIGITS   display value (count, or lap capture while frozen)
//  running    out  1          high in RUNNING or LAP
//  lap_active out  1          high in LAP
//  overflow   out  1          sticky; set when the count passes max; cleared by clear or reset
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; count, disp, running, lap_active and overflow all 0.
//  States and transitions (ss = start_stop, lr = lap_reset):
//   IDLE    ss -> RUNNING; lr ignored
//   RUNNING ss -> STOPPED; lr -> LAP, capturing count into the lap register
//   LAP     ss -> STOPPED, freeze released; lr -> RUNNING, freeze released
//   STOPPED ss -> RUNNING; lr -> IDLE, with count=0 and overflow=0
//  ss and lr high in the same cycle: ss wins, lr is dropped.
//  Counting: count increments on an edge where tick_en=1 AND the current state is RUNNING or LAP.
//   - So a tick coinciding with a stop edge is counted.
//   - A tick coinciding with a start edge is not counted.
//  Counting latency: count shows the new value 1 cycle after the tick edge. No multi-cycle carry.
//  Digit i increments when every lower digit j sits at DIGIT_MOD[j]-1. A digit at its own mod-1 rolls to 0.
//  Overflow: all digits at mod-1 when a tick arrives.
//   - WRAP_MODE=1: count -> 0, overflow <= 1, counting continues.
//   - WRAP_MODE=0: count holds at max, overflow <= 1, state -> STOPPED.
//  disp tracks count combinationally except in LAP, where it drives the lap register.
//  The lap register is loaded with the count value pre-increment on the lap edge.
//  overflow stays set through stop/start/lap; it is cleared only by the STOPPED->IDLE clear.
//  The block never produces a digit >= its modulus. Out-of-range digits cannot be reached from reset.
//  Reset mid-count: immediate return to the reset values; no pending events are retained.
// STRUCTURE
//  Shared header stopwatch_defs.vh holds:
//   - state encodings ST_IDLE, ST_RUNNING, ST_LAP, ST_STOPPED (2 bits)
//   - the default modulus constant for the MM:SS format
//  Sub-module bcd_digit (one per digit, generate loop).
//   - Ports: clk, reset, clr, inc, modulus[3:0]; outputs q[3:0] and at_max.
//   - The carry chain is an AND of at_max from all lower digits with the count enable.
//  Top level: control FSM, overflow/saturate logic, lap register, disp mux.
// TESTING
//  1. Reset mid-count at 3:27 -> all outputs 0 within the same cycle, state IDLE.
//  2. Defaults, ss, then 60 ticks -> count=16'h0100.
//  3. Defaults, WRAP_MODE=1, run from 16'h5959 with 1 tick -> count=16'h0000, overflow=1.
//     Same with WRAP_MODE=0 -> count stays 16'h5959, overflow=1, running=0.
//  4. Run to 16'h0012, lr, then 5 ticks -> disp=16'h0012 and count=16'h0017.
//     Second lr -> disp=16'h0017 and lap_active=0.
//  5. ss and lr in the same cycle while RUNNING -> STOPPED, no lap capture.
//     lr while STOPPED -> count=0, overflow=0, IDLE.
//  6. ss edge with tick_en=1 from IDLE -> count stays 0.
//     Stop edge with tick_en=1 at 16'h0004 -> count=16'h0005.

Source files
------------

// File: rtl/bcd_stopwatch_core_pkg.sv
// Shared definitions for the BCD stopwatch: control state encoding and default digit moduli.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bcd_stopwatch_core_pkg;

   // Control FSM states, 2-bit encoding
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUNNING = 2'd1,
      ST_LAP     = 2'd2,
      ST_STOPPED = 2'd3
   } state_t;

   // MM:SS format, digit0 = LSB nibble: sec units mod 10, sec tens mod 6, min units mod 10, min tens mod 6
   localparam logic [15:0] MMSS_MOD = 16'h6A6A;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit with a programmable modulus; rolls to 0 after modulus-1.
// Latency: q updates one cycle after an inc edge; at_max is combinational from q.
// Backpressure: none; inc is consumed every cycle it is high.
module bcd_digit (
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       inc,
   input  logic [3:0] modulus,
   output logic [3:0] q,
   output logic       at_max
);

   assign at_max = (q == (modulus - 4'd1));

   // Digit register: synchronous clear dominates, otherwise count/roll on inc
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= 4'd0;
      end else if (clr) begin
         q <= 4'd0;
      end else if (inc) begin
         q <= at_max ? 4'd0 : (q + 4'd1);
      end
   end

endmodule

// File: rtl/bcd_stopwatch_core.sv
// Multi-digit BCD stopwatch with run/stop/lap/clear control and a lap-freezable display bus.
// Latency: count and state update one cycle after the controlling edge; disp is combinational.
// Backpressure: none; every tick_en/start_stop/lap_reset pulse is acted on in its cycle.
module bcd_stopwatch_core
   import bcd_stopwatch_core_pkg::*;
#(
   parameter int                  DIGITS    = 4,
   parameter logic [4*DIGITS-1:0] DIGIT_MOD = (4*DIGITS)'(MMSS_MOD),
   parameter int                  WRAP_MODE = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  tick_en,
   input  logic                  start_stop,
   input  logic                  lap_reset,
   output logic [4*DIGITS-1:0]   count,
   output logic [4*DIGITS-1:0]   disp,
   output logic                  running,
   output logic                  lap_active,
   output logic                  overflow
);

   localparam bit SATURATE = (WRAP_MODE == 0);

   state_t                state, state_nx;
   logic [DIGITS-1:0]     at_max;
   logic [DIGITS:0]       lower_max;
   logic [4*DIGITS-1:0]   lap_q;
   logic                  count_en;
   logic                  ovf_evt;
   logic                  sat_evt;
   logic                  lap_load;
   logic                  clr;

   // A tick counts only in the counting states, judged on the state before this edge
   assign count_en = tick_en && ((state == ST_RUNNING) || (state == ST_LAP));
   assign ovf_evt  = count_en && lower_max[DIGITS];
   assign sat_evt  = SATURATE && ovf_evt;
   // start_stop wins over lap_reset in the same cycle
   assign lap_load = (state == ST_RUNNING) && lap_reset && !start_stop;
   assign clr      = (state == ST_STOPPED) && lap_reset && !start_stop;

   // Carry chain: digit i advances when all lower digits sit at their max
   assign lower_max[0] = 1'b1;

   for (genvar i = 0; i < DIGITS; i++) begin : g_dig
      logic dig_inc;
      // In saturate mode the all-max tick must not roll the digits over
      assign dig_inc          = count_en && lower_max[i] && !sat_evt;
      assign lower_max[i + 1] = lower_max[i] & at_max[i];

      bcd_digit u_digit (
         .clk     (clk),
         .reset   (reset),
         .clr     (clr),
         .inc     (dig_inc),
         .modulus (DIGIT_MOD[4*i +: 4]),
         .q       (count[4*i +: 4]),
         .at_max  (at_max[i])
      );
   end

   // Control state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state: start_stop has priority; a saturating overflow forces a stop
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: begin
            if (start_stop) state_nx = ST_RUNNING;
         end
         ST_RUNNING: begin
            if (start_stop)     state_nx = ST_STOPPED;
            else if (lap_reset) state_nx = ST_LAP;
         end
         ST_LAP: begin
            if (start_stop)     state_nx = ST_STOPPED;
            else if (lap_reset) state_nx = ST_RUNNING;
         end
         ST_STOPPED: begin
            if (start_stop)     state_nx = ST_RUNNING;
            else if (lap_reset) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
      if (sat_evt) state_nx = ST_STOPPED;
   end

   // Lap register captures the pre-increment count on the lap edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lap_q <= '0;
      end else if (lap_load) begin
         lap_q <= count;
      end
   end

   // Sticky overflow: only the stopped-state clear (or reset) drops it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow <= 1'b0;
      end else if (clr) begin
         overflow <= 1'b0;
      end else if (ovf_evt) begin
         overflow <= 1'b1;
      end
   end

   // Display follows the live count except while the lap is frozen
   always_comb begin
      disp = count;
      if (state == ST_LAP) disp = lap_q;
   end

   assign running    = (state == ST_RUNNING) || (state == ST_LAP);
   assign lap_active = (state == ST_LAP);

endmodule

// File: tb/tb_bcd_stopwatch_core.sv
module tb_bcd_stopwatch_core;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        tick_en = 1'b0;
   logic        start_stop = 1'b0;
   logic        lap_reset = 1'b0;

   logic [15:0] count_w, disp_w, count_s, disp_s;
   logic        running_w, lap_active_w, overflow_w;
   logic        running_s, lap_active_s, overflow_s;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bcd_stopwatch_core #(.DIGITS(4), .DIGIT_MOD(16'h6A6A), .WRAP_MODE(1)) u_wrap (
      .clk(clk), .reset(reset), .tick_en(tick_en), .start_stop(start_stop),
      .lap_reset(lap_reset), .count(count_w), .disp(disp_w), .running(running_w),
      .lap_active(lap_active_w), .overflow(overflow_w)
   );

   bcd_stopwatch_core #(.DIGITS(4), .DIGIT_MOD(16'h6A6A), .WRAP_MODE(0)) u_sat (
      .clk(clk), .reset(reset), .tick_en(tick_en), .start_stop(start_stop),
      .lap_reset(lap_reset), .count(count_s), .disp(disp_s), .running(running_s),
      .lap_active(lap_active_s), .overflow(overflow_s)
   );

   typedef struct {
      logic        ss;
      logic        lr;
      logic        tick;
      int          reps;
      logic [15:0] cnt;
      logic [15:0] dsp;
      logic        run;
      logic        lap;
      logic        ovf;
   } vec_t;

   vec_t vecs[20];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_w(input string tag, input logic [15:0] c, input logic [15:0] d,
                        input logic r, input logic l, input logic o);
      chk({tag, ".count"},      count_w,             c);
      chk({tag, ".disp"},       disp_w,              d);
      chk({tag, ".running"},    {15'd0, running_w},    {15'd0, r});
      chk({tag, ".lap_active"}, {15'd0, lap_active_w}, {15'd0, l});
      chk({tag, ".overflow"},   {15'd0, overflow_w},   {15'd0, o});
   endtask

   // Drive inputs for n cycles (from negedge), then sample 1ns after the last posedge
   task automatic step(input logic s, input logic l, input logic t, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         start_stop = s;
         lap_reset  = l;
         tick_en    = t;
         @(posedge clk);
         #1;
         start_stop = 1'b0;
         lap_reset  = 1'b0;
         tick_en    = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset      = 1'b0;
      start_stop = 1'b0;
      lap_reset  = 1'b0;
      tick_en    = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      #10ms;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      //            ss    lr    tk    reps  count     disp      run   lap   ovf
      vecs[0]  = '{1'b0, 1'b0, 1'b1, 1,  16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 1,  16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 1'b1, 1,  16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 4,  16'h0004, 16'h0004, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 1'b1, 1,  16'h0005, 16'h0005, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 1'b1, 3,  16'h0005, 16'h0005, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 1,  16'h0005, 16'h0005, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 7,  16'h0012, 16'h0012, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 1,  16'h0012, 16'h0012, 1'b1, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 5,  16'h0017, 16'h0012, 1'b1, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 1,  16'h0017, 16'h0017, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 1'b0, 1,  16'h0017, 16'h0017, 1'b1, 1'b1, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 1'b1, 1,  16'h0018, 16'h0018, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{1'b1, 1'b0, 1'b0, 1,  16'h0018, 16'h0018, 1'b1, 1'b0, 1'b0};
      vecs[14] = '{1'b0, 1'b0, 1'b1, 42, 16'h0100, 16'h0100, 1'b1, 1'b0, 1'b0};
      vecs[15] = '{1'b1, 1'b1, 1'b0, 1,  16'h0100, 16'h0100, 1'b0, 1'b0, 1'b0};
      vecs[16] = '{1'b0, 1'b1, 1'b0, 1,  16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
      vecs[17] = '{1'b1, 1'b0, 1'b0, 1,  16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};
      vecs[18] = '{1'b0, 1'b0, 1'b1, 60, 16'h0100, 16'h0100, 1'b1, 1'b0, 1'b0};
      vecs[19] = '{1'b1, 1'b1, 1'b1, 1,  16'h0101, 16'h0101, 1'b0, 1'b0, 1'b0};

      // Reset values while reset is held
      #12;
      chk_w("reset", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
      chk("reset.sat_count", count_s, 16'h0000);
      do_reset();

      // Table: control sequence on the wrapping instance
      for (int i = 0; i < 20; i++) begin
         step(vecs[i].ss, vecs[i].lr, vecs[i].tick, vecs[i].reps);
         chk_w($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].dsp,
               vecs[i].run, vecs[i].lap, vecs[i].ovf);
      end

      // Async reset mid-count at 03:27 with a pending start_stop
      do_reset();
      step(1'b1, 1'b0, 1'b0, 1);
      step(1'b0, 1'b0, 1'b1, 207);
      chk("midreset.pre_count", count_w, 16'h0327);
      @(negedge clk);
      start_stop = 1'b1;
      tick_en    = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      chk_w("midreset", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      start_stop = 1'b0;
      tick_en    = 1'b0;
      reset      = 1'b1;
      step(1'b0, 1'b0, 1'b1, 1);
      chk_w("midreset.idle", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

      // Overflow at 59:59: wrap vs saturate
      do_reset();
      step(1'b1, 1'b0, 1'b0, 1);
      step(1'b0, 1'b0, 1'b1, 3599);
      chk_w("max", 16'h5959, 16'h5959, 1'b1, 1'b0, 1'b0);
      chk("max.sat_count", count_s, 16'h5959);
      step(1'b0, 1'b0, 1'b1, 1);
      chk_w("wrap", 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1);
      chk("sat.count",    count_s,             16'h5959);
      chk("sat.disp",     disp_s,              16'h5959);
      chk("sat.overflow", {15'd0, overflow_s}, 16'h0001);
      chk("sat.running",  {15'd0, running_s},  16'h0000);
      step(1'b0, 1'b0, 1'b1, 1);
      chk_w("wrap.cont", 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b1);
      chk("sat.hold", count_s, 16'h5959);

      // Overflow is sticky through stop/start/lap, cleared by the stopped clear
      step(1'b1, 1'b0, 1'b0, 1);
      chk_w("ovf.stop", 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1);
      chk_w("ovf.start", 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1);
      chk_w("ovf.lap", 16'h0002, 16'h0001, 1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1);
      chk_w("ovf.stop2", 16'h0002, 16'h0002, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1);
      chk_w("ovf.clear", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
